// File: rtl/bit_sync_pkg.sv
// -----------------------------------------------------------------------------
// bit_sync_pkg
// Shared CDC constants for the flip-flop synchronizer slice.
//   SYNC_STAGES_DEFAULT : default number of flops per synchronized bit.
// -----------------------------------------------------------------------------
package bit_sync_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage : bit_sync_pkg

// File: rtl/bit_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Single-bit chain of STAGES_NUM reset-to-0 flops. The first flop samples the
// foreign-domain input; each following flop takes only the previous flop.
// There is no logic anywhere inside the chain.
// Ports:
//   clk_i   : destination-domain clock (rising edge)
//   rst_ni  : asynchronous active-low reset, clears every stage
//   async_i : asynchronous input bit
//   sync_o  : synchronized bit, driven directly by the last flop
// -----------------------------------------------------------------------------
module sync_chain
    import bit_sync_pkg::*;
#(
    parameter int STAGES_NUM = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    // Attributes keep the chain flops adjacent and stop retiming/merging.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES_NUM-1:0] stage_q;
    logic [STAGES_NUM-1:0] stage_d;

    // Next-state wiring: stage 0 takes the input, stage k takes stage k-1.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = async_i;
        for (int k = 1; k < STAGES_NUM; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Chain registers; reset has priority over the clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= {STAGES_NUM{1'b0}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_o = stage_q[STAGES_NUM-1];

endmodule : sync_chain

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-bit, multi-stage flip-flop synchronizer. Every bit of ASYNC owns an
// independent sync_chain; bits never interact. Multi-bit coherency is the
// sender's job (Gray code or hold-stable handshakes) - this is not a bus
// synchronizer.
// Parameters:
//   STAGES_NUM : flops per bit (>= 1)
//   BUS_WIDTH  : number of independent bits (>= 1)
// Ports:
//   CLK   : destination-domain clock (rising edge)
//   RST   : asynchronous active-low reset, clears all stages
//   ASYNC : asynchronous input bits
//   SYNC  : synchronized bits, registered output of each chain's last flop
// -----------------------------------------------------------------------------
module bit_sync
    import bit_sync_pkg::*;
#(
    parameter int STAGES_NUM = SYNC_STAGES_DEFAULT,
    parameter int BUS_WIDTH  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC
);

    // Refuse to elaborate an illegal configuration rather than build nothing.
    if (STAGES_NUM < 1) begin : g_bad_stages
        $error("bit_sync: STAGES_NUM must be >= 1 (got %0d)", STAGES_NUM);
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("bit_sync: BUS_WIDTH must be >= 1 (got %0d)", BUS_WIDTH);
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        sync_chain #(
            .STAGES_NUM (STAGES_NUM)
        ) u_chain (
            .clk_i   (CLK),
            .rst_ni  (RST),
            .async_i (ASYNC[i]),
            .sync_o  (SYNC[i])
        );
    end

endmodule : bit_sync

// File: tb/tb_bit_sync.sv
// -----------------------------------------------------------------------------
// tb_bit_sync
// Three 8-bit instances (1, 2 and 3 stages) share clock, reset and input.
// Table rows give an input value and its settled output; per-edge
// expectations are pushed to a scoreboard queue when the input is driven and
// popped as each edge's outputs are sampled.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_bit_sync;

    logic       clk;
    logic       rst_n;
    logic [7:0] async_s;
    logic [7:0] sync1_s;
    logic [7:0] sync2_s;
    logic [7:0] sync3_s;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] async_v;
        logic [7:0] exp_v;
    } vec_t;

    typedef struct {
        int         edge_n;
        int         stages;
        logic [7:0] exp_v;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];

    bit_sync #(.STAGES_NUM(1), .BUS_WIDTH(8)) dut1 (
        .CLK (clk), .RST (rst_n), .ASYNC (async_s), .SYNC (sync1_s));
    bit_sync #(.STAGES_NUM(2), .BUS_WIDTH(8)) dut2 (
        .CLK (clk), .RST (rst_n), .ASYNC (async_s), .SYNC (sync2_s));
    bit_sync #(.STAGES_NUM(3), .BUS_WIDTH(8)) dut3 (
        .CLK (clk), .RST (rst_n), .ASYNC (async_s), .SYNC (sync3_s));

    // 5 ns clock: rising edges at 2.5, 7.5, ...; falling edges on multiples of 5.
    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    function automatic logic [7:0] sync_of(int stages);
        case (stages)
            1:       return sync1_s;
            2:       return sync2_s;
            default: return sync3_s;
        endcase
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string name, logic [7:0] exp);
        check({name, "/s1"}, sync1_s, exp);
        check({name, "/s2"}, sync2_s, exp);
        check({name, "/s3"}, sync3_s, exp);
    endtask

    // Input (or reset release) has just changed mid-cycle; the instance with
    // S stages must still show old_v after edges 1..S-1 and new_v from edge S.
    task automatic track(string name, logic [7:0] new_v, logic [7:0] old_v);
        sb_t e;
        for (int ed = 1; ed <= 3; ed++) begin
            for (int s = 1; s <= 3; s++) begin
                sb_q.push_back('{edge_n: ed, stages: s,
                                 exp_v: (ed >= s) ? new_v : old_v});
            end
        end
        for (int ed = 1; ed <= 3; ed++) begin
            @(posedge clk);
            #1;
            for (int s = 1; s <= 3; s++) begin
                e = sb_q.pop_front();
                check($sformatf("%s/edge%0d/s%0d", name, e.edge_n, e.stages),
                      sync_of(e.stages), e.exp_v);
            end
        end
    endtask

    initial begin
        logic [7:0] prev_v;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{8'h3C, 8'h3C};
        vecs[1] = '{8'hFF, 8'hFF};
        vecs[2] = '{8'h00, 8'h00};
        vecs[3] = '{8'h81, 8'h81};
        vecs[4] = '{8'h5A, 8'h5A};
        vecs[5] = '{8'h00, 8'h00};
        vecs[6] = '{8'h0F, 8'h0F};
        vecs[7] = '{8'h00, 8'h00};
        vecs[8] = '{8'h80, 8'h80};
        vecs[9] = '{8'hFF, 8'hFF};

        // Reset held from time 0 with input nonzero and clock running.
        rst_n   = 1'b0;
        async_s = 8'hA5;
        #1;
        check_all("reset_t1", 8'h00);
        #4;
        check_all("reset_t5", 8'h00);

        // Release between edges; A5 appears after exactly S rising edges.
        @(negedge clk);
        rst_n = 1'b1;
        track("reset_release", 8'hA5, 8'h00);

        // Table-driven latency / bit-independence vectors.
        prev_v = 8'hA5;
        foreach (vecs[i]) begin
            @(negedge clk);
            async_s = vecs[i].async_v;
            track($sformatf("vec%0d", i), vecs[i].async_v, prev_v);
            @(negedge clk);
            check_all($sformatf("vec%0d_hold", i), vecs[i].exp_v);
            prev_v = vecs[i].exp_v;
        end

        // Reset mid-stream with FF settled: outputs clear before any edge.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #0.5;
        check_all("midreset_immediate", 8'h00);
        @(posedge clk);
        #1;
        check_all("midreset_held", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        track("midreset_release", 8'hFF, 8'h00);

        // Input change coincident with reset assertion: reset wins.
        @(negedge clk);
        rst_n   = 1'b0;
        async_s = 8'h3C;
        #0.5;
        check_all("reset_with_change", 8'h00);
        @(posedge clk);
        #1;
        check_all("reset_with_change_edge", 8'h00);
        @(negedge clk);
        async_s = 8'h00;
        rst_n   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all("zero_settled", 8'h00);

        // 1 ns pulse on bit 0 well clear of any rising edge is never captured.
        @(negedge clk);
        #0.5;
        async_s = 8'h01;
        #1;
        async_s = 8'h00;
        for (int ed = 1; ed <= 4; ed++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("short_pulse_edge%0d", ed), 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bit_sync
